// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue stage: decodes RISC-V OP/OP-IMM funct fields, executes on a local
// 3-bit-control ALU and returns the tagged result. Optional SLT/SLTU via ALU_ISSUE_SLT_EN.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Flush,
   input  logic              InValid,
   output logic              InReady,
   input  logic              IsImm,
   input  logic [2:0]        Funct3,
   input  logic              Funct7b5,
   input  logic [DATA_W-1:0] Rs1Val,
   input  logic [DATA_W-1:0] Rs2Val,
   input  logic [DATA_W-1:0] Imm,
   input  logic [TAG_W-1:0]  RdIn,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] Result,
   output logic [TAG_W-1:0]  RdOut,
   output logic              Illegal
);

   // Alu3bit control encoding (ADD/SUB/AND/OR/XOR/SLL/SRL/SRA)
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SRA = 3'd7;

   logic              s1_valid;
   logic [2:0]        s1_ctrl;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [TAG_W-1:0]  s1_rd;
   logic              s1_illegal;
   logic              s2_valid;
   logic              s2_ready;

   logic [2:0]        dec_ctrl;
   logic              dec_illegal;
   logic              dec_shift;
   logic [DATA_W-1:0] b_raw;
   logic [DATA_W-1:0] dec_b;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] exec_res;

`ifdef ALU_ISSUE_SLT_EN
   logic dec_cmp;
   logic dec_cmp_u;
   logic s1_cmp;
   logic s1_cmp_u;
   logic cmp_lt;
`endif

   assign s2_ready = !s2_valid || OutReady;
   assign InReady  = !s1_valid || s2_ready;
   assign OutValid = s2_valid;

   always_comb begin
      dec_ctrl    = ALU_ADD;
      dec_illegal = 1'b0;
      dec_shift   = 1'b0;
`ifdef ALU_ISSUE_SLT_EN
      dec_cmp     = 1'b0;
      dec_cmp_u   = 1'b0;
`endif
      case (Funct3)
         3'b000: dec_ctrl = (!IsImm && Funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001: begin
            dec_ctrl    = ALU_SLL;
            dec_shift   = 1'b1;
            dec_illegal = Funct7b5;
         end
         3'b100: dec_ctrl = ALU_XOR;
         3'b101: begin
            dec_ctrl  = Funct7b5 ? ALU_SRA : ALU_SRL;
            dec_shift = 1'b1;
         end
         3'b110: dec_ctrl = ALU_OR;
         3'b111: dec_ctrl = ALU_AND;
         default: begin
`ifdef ALU_ISSUE_SLT_EN
            dec_cmp   = 1'b1;
            dec_cmp_u = Funct3[0];
`else
            dec_illegal = 1'b1;
`endif
         end
      endcase
      // for OP-IMM, bit 30 is just immediate data except on shifts
      if (!IsImm && Funct7b5 && Funct3 != 3'b000 && Funct3 != 3'b101)
         dec_illegal = 1'b1;
   end

   assign b_raw = IsImm ? Imm : Rs2Val;
   assign dec_b = dec_shift ? {{(DATA_W-5){1'b0}}, b_raw[4:0]} : b_raw;

   always_comb begin
      alu_res = '0;
      case (s1_ctrl)
         ALU_ADD: alu_res = s1_a + s1_b;
         ALU_SUB: alu_res = s1_a - s1_b;
         ALU_AND: alu_res = s1_a & s1_b;
         ALU_OR:  alu_res = s1_a | s1_b;
         ALU_XOR: alu_res = s1_a ^ s1_b;
         ALU_SLL: alu_res = s1_a << s1_b[4:0];
         ALU_SRL: alu_res = s1_a >> s1_b[4:0];
         ALU_SRA: alu_res = $signed(s1_a) >>> s1_b[4:0];
         default: alu_res = '0;
      endcase
   end

`ifdef ALU_ISSUE_SLT_EN
   assign cmp_lt   = s1_cmp_u ? (s1_a < s1_b) : ($signed(s1_a) < $signed(s1_b));
   assign exec_res = s1_cmp ? {{(DATA_W-1){1'b0}}, cmp_lt} : alu_res;
`else
   assign exec_res = alu_res;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_ctrl    <= '0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_rd      <= '0;
         s1_illegal <= 1'b0;
`ifdef ALU_ISSUE_SLT_EN
         s1_cmp     <= 1'b0;
         s1_cmp_u   <= 1'b0;
`endif
      end else if (Flush) begin
         s1_valid <= 1'b0;
      end else if (InValid && InReady) begin
         s1_valid   <= 1'b1;
         s1_ctrl    <= dec_ctrl;
         s1_a       <= Rs1Val;
         s1_b       <= dec_b;
         s1_rd      <= RdIn;
         s1_illegal <= dec_illegal;
`ifdef ALU_ISSUE_SLT_EN
         s1_cmp     <= dec_cmp;
         s1_cmp_u   <= dec_cmp_u;
`endif
      end else if (s2_ready) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         Result   <= '0;
         RdOut    <= '0;
         Illegal  <= 1'b0;
      end else if (Flush) begin
         s2_valid <= 1'b0;
      end else if (s1_valid && s2_ready) begin
         s2_valid <= 1'b1;
         Result   <= s1_illegal ? '0 : exec_res;
         RdOut    <= s1_rd;
         Illegal  <= s1_illegal;
      end else if (OutReady) begin
         s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expected values are hand-computed.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Flush = 1'b0;
   logic        InValid = 1'b0;
   logic        InReady;
   logic        IsImm = 1'b0;
   logic [2:0]  Funct3 = 3'b000;
   logic        Funct7b5 = 1'b0;
   logic [31:0] Rs1Val = '0;
   logic [31:0] Rs2Val = '0;
   logic [31:0] Imm = '0;
   logic [4:0]  RdIn = '0;
   logic        OutValid;
   logic        OutReady = 1'b1;
   logic [31:0] Result;
   logic [4:0]  RdOut;
   logic        Illegal;

   int n_checks = 0;
   int n_pass   = 0;

   alu_issue_stage #(.DATA_W(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .Flush(Flush),
      .InValid(InValid), .InReady(InReady),
      .IsImm(IsImm), .Funct3(Funct3), .Funct7b5(Funct7b5),
      .Rs1Val(Rs1Val), .Rs2Val(Rs2Val), .Imm(Imm), .RdIn(RdIn),
      .OutValid(OutValid), .OutReady(OutReady),
      .Result(Result), .RdOut(RdOut), .Illegal(Illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      if (obs === want) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic imm_sel, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rd);
      IsImm = imm_sel; Funct3 = f3; Funct7b5 = f7;
      Rs1Val = a; Rs2Val = b; Imm = im; RdIn = rd;
   endtask

   // single op through an idle pipe, no backpressure
   task automatic run_one(input string tag, input logic imm_sel, input logic [2:0] f3,
                          input logic f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [4:0] rd,
                          input logic [31:0] want, input logic want_ill);
      OutReady = 1'b1;
      set_op(imm_sel, f3, f7, a, b, im, rd);
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      tick();
      check({tag, "_valid"}, OutValid, 1'b1);
      check({tag, "_res"}, Result, want);
      check({tag, "_rd"}, RdOut, rd);
      check({tag, "_ill"}, Illegal, want_ill);
      tick();
   endtask

   initial begin
      int accepted;
      int n_out;
      logic [4:0]  got_rd [4];
      logic [31:0] got_res [4];

      // reset / idle
      #2;
      check("rst_outvalid", OutValid, 1'b0);
      check("rst_result", Result, 32'h0);
      check("rst_rdout", RdOut, 5'h0);
      check("rst_illegal", Illegal, 1'b0);
      #10 rst = 1'b0;
      tick();
      check("idle_inready", InReady, 1'b1);
      check("idle_outvalid", OutValid, 1'b0);

      // streaming ADD then SUB
      OutReady = 1'b1;
      set_op(1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd1);
      InValid = 1'b1;
      tick();
      check("stream_inready", InReady, 1'b1);
      set_op(1'b0, 3'b000, 1'b1, 32'd5, 32'd7, 32'h0, 5'd2);
      tick();
      InValid = 1'b0;
      check("add_valid", OutValid, 1'b1);
      check("add_res", Result, 32'h0);
      check("add_rd", RdOut, 5'd1);
      tick();
      check("sub_valid", OutValid, 1'b1);
      check("sub_res", Result, 32'hFFFF_FFFE);
      check("sub_rd", RdOut, 5'd2);
      tick();
      check("stream_drain", OutValid, 1'b0);

      // shifts and logic ops
      run_one("srai", 1'b1, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h0000_0024, 5'd3, 32'hF800_0000, 1'b0);
      run_one("sll",  1'b0, 3'b001, 1'b0, 32'h0000_0003, 32'h21, 32'h0, 5'd4, 32'h0000_0006, 1'b0);
      run_one("srl31", 1'b0, 3'b101, 1'b0, 32'h8000_0000, 32'h1F, 32'h0, 5'd5, 32'h0000_0001, 1'b0);
      run_one("sra0", 1'b0, 3'b101, 1'b1, 32'h8000_0000, 32'h20, 32'h0, 5'd6, 32'h8000_0000, 1'b0);
      run_one("addi_f7", 1'b1, 3'b000, 1'b1, 32'd10, 32'd99, 32'd1, 5'd7, 32'd11, 1'b0);
      run_one("and",  1'b0, 3'b111, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h0, 5'd8, 32'h00F0_000F, 1'b0);
      run_one("ori",  1'b1, 3'b110, 1'b0, 32'h1200_0034, 32'h0, 32'h0000_0F00, 5'd9, 32'h1200_0F34, 1'b0);
      run_one("xor",  1'b0, 3'b100, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 5'd10, 32'hF0F0_0F0F, 1'b0);
      run_one("xori_f7", 1'b1, 3'b100, 1'b1, 32'h0000_00FF, 32'h0, 32'h0000_000F, 5'd11, 32'h0000_00F0, 1'b0);

      // illegal encodings
      run_one("slli_f7", 1'b1, 3'b001, 1'b1, 32'h1, 32'h0, 32'h1, 5'd12, 32'h0, 1'b1);
      run_one("and_f7",  1'b0, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd13, 32'h0, 1'b1);
      run_one("slt_f7",  1'b0, 3'b010, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd14, 32'h0, 1'b1);
`ifdef ALU_ISSUE_SLT_EN
      run_one("slt",  1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd15, 32'h1, 1'b0);
      run_one("sltu", 1'b0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd16, 32'h0, 1'b0);
`else
      run_one("slt_off",  1'b0, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd15, 32'h0, 1'b1);
      run_one("sltu_off", 1'b0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd16, 32'h0, 1'b1);
`endif

      // backpressure: OutReady low for 5 cycles, upstream always offering
      OutReady = 1'b0;
      accepted = 0;
      for (int c = 0; c < 5; c++) begin
         set_op(1'b0, 3'b000, 1'b0, 32'd100 + 32'(accepted), 32'd1, 32'h0, 5'(10 + accepted));
         InValid = 1'b1;
         if (c >= 2) check($sformatf("bp_stable_%0d", c), Result, 32'd101);
         if (InReady) accepted++;
         tick();
      end
      InValid = 1'b0;
      check("bp_accepted", 32'(accepted), 32'd2);
      check("bp_inready", InReady, 1'b0);
      check("bp_res", Result, 32'd101);
      check("bp_rd", RdOut, 5'd10);
      OutReady = 1'b1;
      n_out = 0;
      for (int c = 0; c < 8; c++) begin
         if (OutValid && n_out < 4) begin
            got_rd[n_out]  = RdOut;
            got_res[n_out] = Result;
            n_out++;
         end
         tick();
      end
      check("bp_count", 32'(n_out), 32'd2);
      check("bp_rd0", got_rd[0], 5'd10);
      check("bp_res0", got_res[0], 32'd101);
      check("bp_rd1", got_rd[1], 5'd11);
      check("bp_res1", got_res[1], 32'd102);

      // flush with both stages full and an input offered
      OutReady = 1'b0;
      set_op(1'b0, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 5'd20);
      InValid = 1'b1;
      tick();
      set_op(1'b0, 3'b000, 1'b0, 32'd2, 32'd1, 32'h0, 5'd21);
      tick();
      check("fl_full_valid", OutValid, 1'b1);
      check("fl_full_rd", RdOut, 5'd20);
      OutReady = 1'b1;
      set_op(1'b0, 3'b000, 1'b0, 32'd3, 32'd1, 32'h0, 5'd22);
      Flush = 1'b1;
      #1;
      check("fl_inready", InReady, 1'b1);
      @(posedge clk);
      #1;
      Flush = 1'b0;
      InValid = 1'b0;
      check("fl_outvalid", OutValid, 1'b0);
      n_out = 0;
      for (int c = 0; c < 4; c++) begin
         if (OutValid) n_out++;
         tick();
      end
      check("fl_no_ghost", 32'(n_out), 32'd0);
      run_one("fl_after", 1'b0, 3'b000, 1'b0, 32'd40, 32'd2, 32'h0, 5'd23, 32'd42, 1'b0);

      // reset while a result is held
      OutReady = 1'b0;
      set_op(1'b0, 3'b000, 1'b0, 32'd3, 32'd4, 32'h0, 5'd5);
      InValid = 1'b1;
      tick();
      InValid = 1'b0;
      tick();
      check("mr_pre_res", Result, 32'd7);
      #2 rst = 1'b1;
      #1;
      check("mr_outvalid", OutValid, 1'b0);
      check("mr_result", Result, 32'h0);
      check("mr_rdout", RdOut, 5'h0);
      #3 rst = 1'b0;
      OutReady = 1'b1;
      tick();
      check("mr_inready", InReady, 1'b1);
      check("mr_idle", OutValid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
